// File: rtl/divfreq_pkg.sv
// Shared constants and helpers for the divfreq clock-divider bank.
package divfreq_pkg;

    // Default half-periods in system clocks (50 MHz: 10 Hz, 5 Hz, 1 kHz).
    localparam int DIV1_DEF = 2_500_000;
    localparam int DIV2_DEF = 5_000_000;
    localparam int DIV3_DEF = 25_000;

    // Counter width for a half-period of x cycles: max(1, clog2(x)).
    function automatic int cnt_width(input int x);
        int w;
        w = $clog2(x);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/divfreq_core.sv
// One divider channel: counts DIV system clocks per half-period and toggles a
// registered square wave. Optional single-cycle tick under DIVFREQ_TICK_EN.
module divfreq_core
    import divfreq_pkg::*;
#(
    parameter int DIV = DIV1_DEF
) (
    input  logic CLK,
    input  logic Clear,
    output logic clk_out
`ifdef DIVFREQ_TICK_EN
    ,
    output logic tick
`endif
);

    localparam int CW = cnt_width(DIV);
    localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

    // A zero half-period has no meaning; refuse to elaborate.
    if (DIV < 1) begin : g_div_check
        $fatal(1, "divfreq_core: DIV must be >= 1 (got %0d)", DIV);
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          wrap;
`ifdef DIVFREQ_TICK_EN
    logic          tick_q, tick_d;
`endif

    // Next-state: wrap the counter and flip the output at the end of a half-period.
    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        out_d = wrap ? ~out_q : out_q;
`ifdef DIVFREQ_TICK_EN
        tick_d = wrap;
`endif
    end

    // State registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (Clear) begin
            cnt_q <= '0;
            out_q <= 1'b0;
`ifdef DIVFREQ_TICK_EN
            tick_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
`ifdef DIVFREQ_TICK_EN
            tick_q <= tick_d;
`endif
        end
    end

    assign clk_out = out_q;
`ifdef DIVFREQ_TICK_EN
    assign tick    = tick_q;
`endif

endmodule

// File: rtl/divfreq_bank.sv
// Bank of three independent clock dividers sharing one clock and clear.
// Define DIVFREQ_TICK_EN to add the tick1..tick3 single-cycle strobes.
module divfreq_bank
    import divfreq_pkg::*;
#(
    parameter int DIV1 = DIV1_DEF,
    parameter int DIV2 = DIV2_DEF,
    parameter int DIV3 = DIV3_DEF
) (
    input  logic CLK,
    input  logic Clear,
    output logic CLK_div,
    output logic CLK_div2,
    output logic CLK_div3
`ifdef DIVFREQ_TICK_EN
    ,
    output logic tick1,
    output logic tick2,
    output logic tick3
`endif
);

    divfreq_core #(.DIV(DIV1)) u_ch1 (
        .CLK     (CLK),
        .Clear   (Clear),
        .clk_out (CLK_div)
`ifdef DIVFREQ_TICK_EN
        ,
        .tick    (tick1)
`endif
    );

    divfreq_core #(.DIV(DIV2)) u_ch2 (
        .CLK     (CLK),
        .Clear   (Clear),
        .clk_out (CLK_div2)
`ifdef DIVFREQ_TICK_EN
        ,
        .tick    (tick2)
`endif
    );

    divfreq_core #(.DIV(DIV3)) u_ch3 (
        .CLK     (CLK),
        .Clear   (Clear),
        .clk_out (CLK_div3)
`ifdef DIVFREQ_TICK_EN
        ,
        .tick    (tick3)
`endif
    );

endmodule

// File: tb/tb_divfreq_bank.sv
// Scoreboard bench for divfreq_bank: stimulus pushes the expected outputs for
// each clock edge, a monitor pops and compares after every edge.
module tb_divfreq_bank;

    localparam int D1 = 4;
    localparam int D2 = 6;
    localparam int D3 = 1;

    logic CLK;
    logic Clear;
    logic CLK_div, CLK_div2, CLK_div3;
    logic eq_div, eq_div2, eq_div3;
`ifdef DIVFREQ_TICK_EN
    logic tick1, tick2, tick3;
    logic eq_tick1, eq_tick2, eq_tick3;
`endif

    int chk = 0;
    int err = 0;
    int k   = 0;
    logic [5:0] exp_q[$];

    divfreq_bank #(.DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .CLK      (CLK),
        .Clear    (Clear),
        .CLK_div  (CLK_div),
        .CLK_div2 (CLK_div2),
        .CLK_div3 (CLK_div3)
`ifdef DIVFREQ_TICK_EN
        ,
        .tick1    (tick1),
        .tick2    (tick2),
        .tick3    (tick3)
`endif
    );

    // Second instance with equal half-periods on channels 1 and 2.
    divfreq_bank #(.DIV1(5), .DIV2(5), .DIV3(2)) dut_eq (
        .CLK      (CLK),
        .Clear    (Clear),
        .CLK_div  (eq_div),
        .CLK_div2 (eq_div2),
        .CLK_div3 (eq_div3)
`ifdef DIVFREQ_TICK_EN
        ,
        .tick1    (eq_tick1),
        .tick2    (eq_tick2),
        .tick3    (eq_tick3)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        chk++;
        if (act != exp) begin
            err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Expected {tick3,tick2,tick1,out3,out2,out1} after kk un-cleared edges.
    function automatic logic [5:0] model(input int kk);
        logic [5:0] r;
        r[0] = ((kk / D1) % 2) == 1;
        r[1] = ((kk / D2) % 2) == 1;
        r[2] = ((kk / D3) % 2) == 1;
        r[3] = (kk != 0) && ((kk % D1) == 0);
        r[4] = (kk != 0) && ((kk % D2) == 0);
        r[5] = (kk != 0) && ((kk % D3) == 0);
        return r;
    endfunction

    // Set Clear for the coming edge and queue what that edge must produce.
    task automatic step(input logic clr);
        @(negedge CLK);
        Clear = clr;
        if (clr) k = 0;
        else k++;
        exp_q.push_back(model(k));
    endtask

    // Point checks on hand-derived edge numbers after a release.
    task automatic point_checks();
        if (k == 3) check("div1_low_edge3", CLK_div, 1'b0);
        if (k == 4) check("div1_rise_edge4", CLK_div, 1'b1);
        if (k == 7) check("div1_high_edge7", CLK_div, 1'b1);
        if (k == 8) check("div1_fall_edge8", CLK_div, 1'b0);
        if (k == 5) check("div2_low_edge5", CLK_div2, 1'b0);
        if (k == 6) check("div2_rise_edge6", CLK_div2, 1'b1);
        if (k == 1) check("div3_high_edge1", CLK_div3, 1'b1);
        if (k == 2) check("div3_low_edge2", CLK_div3, 1'b0);
    endtask

    // Monitor: compare every output after each edge against the queued value.
    initial begin
        logic [5:0] e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("CLK_div", CLK_div, e[0]);
                check("CLK_div2", CLK_div2, e[1]);
                check("CLK_div3", CLK_div3, e[2]);
`ifdef DIVFREQ_TICK_EN
                check("tick1", tick1, e[3]);
                check("tick2", tick2, e[4]);
                check("tick3", tick3, e[5]);
                check("eq_tick_match", eq_tick2, eq_tick1);
`endif
                check("eq_div_match", eq_div2, eq_div);
            end
        end
    end

    initial begin
        logic v, prev;
        int   run, rises;
        prev  = 1'b0;
        run   = 0;
        rises = 0;
        Clear = 1'b1;
        repeat (3) step(1'b1);
        @(posedge CLK);
        #3;
        check("div1_in_reset", CLK_div, 1'b0);
        check("div2_in_reset", CLK_div2, 1'b0);
        check("div3_in_reset", CLK_div3, 1'b0);

        // First release: 9 edges leaves channel 2 high with its count at 3.
        for (int i = 0; i < 9; i++) begin
            step(1'b0);
            @(posedge CLK);
            #3;
            point_checks();
        end
        check("div2_high_before_clear", CLK_div2, 1'b1);

        // One-cycle clear mid-count.
        step(1'b1);
        @(posedge CLK);
        #3;
        check("div2_zero_after_clear", CLK_div2, 1'b0);
        check("div1_zero_after_clear", CLK_div, 1'b0);

        // Second release: phase lengths and rise count over a 100-cycle window.
        for (int i = 0; i < 110; i++) begin
            step(1'b0);
            @(posedge CLK);
            #3;
            point_checks();
            v = CLK_div;
            if (k == 4) begin
                prev  = v;
                run   = 1;
                rises = 0;
            end else if (k > 4 && k <= 104) begin
                if (v !== prev) begin
                    check_int("div1_phase_len", run, D1);
                    if (v === 1'b1) rises++;
                    run  = 1;
                    prev = v;
                end else begin
                    run++;
                end
            end
        end
        check_int("div1_rises_100", rises, 12);

        repeat (3) @(posedge CLK);
        #3;
        check_int("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
